// File: rtl/traffic_phase_monitor_if.sv
// Lamp observation bus between the lamp driver side and the phase monitor.
interface traffic_phase_monitor_if;
    logic [2:0] light;
    logic       clearErr;
    logic [1:0] phase;
    logic       locked;
    logic       phaseDone;
    logic       errIllegal;
    logic       errSequence;
    logic       errTiming;
    logic [7:0] errCount;

    modport master (
        output light, clearErr,
        input  phase, locked, phaseDone, errIllegal, errSequence, errTiming, errCount
    );

    modport slave (
        input  light, clearErr,
        output phase, locked, phaseDone, errIllegal, errSequence, errTiming, errCount
    );
endinterface

// File: rtl/traffic_phase_monitor.sv
// Traffic light phase monitor: checks G->Y->R->G order and exact dwell per phase.
// Optional macro TRAFFIC_MON_ERRCNT_EN adds the saturating error-event counter;
// without it errCount is tied to zero.
module traffic_phase_monitor #(
    parameter int unsigned GREEN_TIME  = 55,
    parameter int unsigned YELLOW_TIME = 5,
    parameter int unsigned RED_TIME    = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_phase_monitor_if.slave mon
);

    localparam int unsigned   CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]    L_G     = 3'b001;
    localparam logic [2:0]    L_Y     = 3'b010;
    localparam logic [2:0]    L_R     = 3'b100;

    typedef enum logic {SYNC, TRACK} state_t;

    state_t           state_q, state_d;
    logic [2:0]       light_q, light_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       phase_q, phase_d;
    logic             locked_q, locked_d;
    logic             phase_done_q, phase_done_d;
    logic             err_illegal_q, err_illegal_d;
    logic             err_sequence_q, err_sequence_d;
    logic             err_timing_q, err_timing_d;

    logic             light_legal;
    logic             change;
    logic             hold;
    logic             set_illegal;
    logic             set_sequence;
    logic             set_timing;

    function automatic logic is_legal(input logic [2:0] l);
        return (l == L_G) || (l == L_Y) || (l == L_R);
    endfunction

    function automatic logic [CNT_W-1:0] dwell_limit(input logic [2:0] l);
        logic [CNT_W-1:0] t;
        case (l)
            L_G:     t = CNT_W'(GREEN_TIME);
            L_Y:     t = CNT_W'(YELLOW_TIME);
            L_R:     t = CNT_W'(RED_TIME);
            default: t = '0;
        endcase
        return t;
    endfunction

    function automatic logic [2:0] successor(input logic [2:0] l);
        logic [2:0] s;
        case (l)
            L_G:     s = L_Y;
            L_Y:     s = L_R;
            L_R:     s = L_G;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] decode(input logic [2:0] l);
        logic [1:0] p;
        case (l)
            L_G:     p = 2'd1;
            L_Y:     p = 2'd2;
            L_R:     p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // Phase tracking, checks and next-state/output computation.
    always_comb begin
        state_d      = state_q;
        overrun_d    = overrun_q;
        set_sequence = 1'b0;
        set_timing   = 1'b0;
        phase_done_d = 1'b0;

        light_legal = is_legal(mon.light);
        change      = light_legal && is_legal(light_q) && (mon.light != light_q);
        hold        = light_legal && (mon.light == light_q);
        set_illegal = !light_legal;

        light_d = mon.light;
        if (mon.light != light_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (!light_legal) begin
            state_d   = SYNC;
            overrun_d = 1'b0;
        end else if (change) begin
            overrun_d = 1'b0;
            if (state_q == SYNC) begin
                state_d = TRACK;
            end else begin
                // An overrun already reported for this phase suppresses the end-of-phase timing error.
                set_sequence = (mon.light != successor(light_q));
                set_timing   = (cnt_q != dwell_limit(light_q)) && !overrun_q;
                phase_done_d = (mon.light == successor(light_q)) &&
                               (cnt_q == dwell_limit(light_q));
            end
        end else if (hold && (state_q == TRACK) && !overrun_q &&
                     (cnt_q == dwell_limit(light_q))) begin
            // This cycle takes the dwell one past its limit.
            set_timing = 1'b1;
            overrun_d  = 1'b1;
        end

        locked_d = (state_d == TRACK);
        phase_d  = (state_d == TRACK) ? decode(mon.light) : 2'd0;

        err_illegal_d  = set_illegal  || (err_illegal_q  && !mon.clearErr);
        err_sequence_d = set_sequence || (err_sequence_q && !mon.clearErr);
        err_timing_d   = set_timing   || (err_timing_q   && !mon.clearErr);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SYNC;
            light_q        <= 3'b000;
            cnt_q          <= '0;
            overrun_q      <= 1'b0;
            phase_q        <= 2'd0;
            locked_q       <= 1'b0;
            phase_done_q   <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_sequence_q <= 1'b0;
            err_timing_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            light_q        <= light_d;
            cnt_q          <= cnt_d;
            overrun_q      <= overrun_d;
            phase_q        <= phase_d;
            locked_q       <= locked_d;
            phase_done_q   <= phase_done_d;
            err_illegal_q  <= err_illegal_d;
            err_sequence_q <= err_sequence_d;
            err_timing_q   <= err_timing_d;
        end
    end

`ifdef TRAFFIC_MON_ERRCNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_event;

    // Saturating error-event count; an event in a clearing cycle restarts the count at one.
    always_comb begin
        err_count_d = err_count_q;
        err_event   = set_illegal || set_sequence || set_timing;
        if (err_event) begin
            if (mon.clearErr) begin
                err_count_d = CNT_W'(1);
            end else if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end else if (mon.clearErr) begin
            err_count_d = '0;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign mon.errCount = err_count_q;
`else
    assign mon.errCount = '0;
`endif

    assign mon.phase       = phase_q;
    assign mon.locked      = locked_q;
    assign mon.phaseDone   = phase_done_q;
    assign mon.errIllegal  = err_illegal_q;
    assign mon.errSequence = err_sequence_q;
    assign mon.errTiming   = err_timing_q;

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Bench for traffic_phase_monitor: table of phase segments, directed corner
// sequences and random phase streams, all checked against a cycle-level model.
module tb_traffic_phase_monitor;

    localparam int G_T = 55;
    localparam int Y_T = 5;
    localparam int R_T = 30;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
`ifdef TRAFFIC_MON_ERRCNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    traffic_phase_monitor_if mon_if ();

    traffic_phase_monitor #(
        .GREEN_TIME  (G_T),
        .YELLOW_TIME (Y_T),
        .RED_TIME    (R_T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon_if)
    );

    // Reference model: what an observer of the lamps concludes after each clock.
    logic [2:0] m_prev;
    int  m_run, m_cnt, m_phase;
    bit  m_locked, m_reported, m_done, m_ill, m_seq, m_tim;

    function automatic bit legal(input logic [2:0] l);
        return (l == G) || (l == Y) || (l == R);
    endfunction

    function automatic int dwell(input logic [2:0] l);
        return (l == G) ? G_T : (l == Y) ? Y_T : (l == R) ? R_T : 0;
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] l);
        return (l == G) ? Y : (l == Y) ? R : (l == R) ? G : 3'b000;
    endfunction

    function automatic int phase_code(input logic [2:0] l);
        return (l == G) ? 1 : (l == Y) ? 2 : (l == R) ? 3 : 0;
    endfunction

    task automatic model_update(input logic [2:0] l, input bit clr, input bit rst);
        bit ev_ill, ev_seq, ev_tim;
        if (rst) begin
            m_prev = 3'b000; m_run = 0; m_cnt = 0; m_phase = 0;
            m_locked = 0; m_reported = 0; m_done = 0; m_ill = 0; m_seq = 0; m_tim = 0;
        end else begin
            ev_ill = !legal(l);
            ev_seq = 0;
            ev_tim = 0;
            m_done = 0;
            if (!legal(l)) begin
                m_locked   = 0;
                m_reported = 0;
            end else if (legal(m_prev) && l != m_prev) begin
                if (m_locked) begin
                    ev_seq = (l != succ(m_prev));
                    ev_tim = (m_run != dwell(m_prev)) && !m_reported;
                    m_done = !ev_seq && (m_run == dwell(m_prev));
                end
                m_locked   = 1;
                m_reported = 0;
            end else if (m_locked && l == m_prev && m_run + 1 > dwell(m_prev) && !m_reported) begin
                ev_tim     = 1;
                m_reported = 1;
            end
            m_run  = (l != m_prev) ? 1 : ((m_run < 255) ? m_run + 1 : 255);
            m_prev = l;
            m_ill  = ev_ill || (m_ill && !clr);
            m_seq  = ev_seq || (m_seq && !clr);
            m_tim  = ev_tim || (m_tim && !clr);
            if (CNT_EN != 0) begin
                if (ev_ill || ev_seq || ev_tim) m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
                else if (clr) m_cnt = 0;
            end
            m_phase = m_locked ? phase_code(l) : 0;
        end
    endtask

    function automatic logic [14:0] pack_out(input int ph, input bit lk, input bit dn,
                                             input bit il, input bit sq, input bit tm, input int ct);
        return {2'(ph), lk, dn, il, sq, tm, 8'(ct)};
    endfunction

    function automatic logic [14:0] dut_out();
        return {mon_if.phase, mon_if.locked, mon_if.phaseDone, mon_if.errIllegal,
                mon_if.errSequence, mon_if.errTiming, mon_if.errCount};
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got {ph,lk,dn,il,sq,tm,cnt}=%h required %h", name, $time, got, exp);
        end
    endtask

    // One clock: drive, clock, update model, sample 1 time unit after the edge.
    task automatic step(input logic [2:0] l, input bit clr, input bit rst);
        mon_if.light    = l;
        mon_if.clearErr = clr;
        reset           = rst;
        @(posedge clk);
        model_update(l, clr, rst);
        #1;
        check("model", dut_out(),
              pack_out(m_phase, m_locked, m_done, m_ill, m_seq, m_tim, m_cnt));
    endtask

    task automatic hold_light(input logic [2:0] l, input int n);
        for (int k = 0; k < n; k++) step(l, 1'b0, 1'b0);
    endtask

    task automatic check_out(input string name, input int ph, input bit lk, input bit dn,
                             input bit il, input bit sq, input bit tm, input int ct);
        check(name, dut_out(), pack_out(ph, lk, dn, il, sq, tm, CNT_EN != 0 ? ct : 0));
    endtask

    typedef struct {
        string      name;
        logic [2:0] light;
        bit         clr;
        int         len;
        int         ph;
        bit         lk, dn, il, sq, tm;
        int         ct;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Expected outputs are those seen after the first clock of each segment.
        tbl[0]  = '{"first_green",   G, 0, 10, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{"lock_on_y",     Y, 0,  5, 2, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{"y_to_r_done",   R, 0, 30, 3, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{"r_to_g_done",   G, 0, 55, 1, 1, 1, 0, 0, 0, 0};
        tbl[4]  = '{"g_to_y_done",   Y, 0,  5, 2, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{"y_to_r_done2",  R, 0, 30, 3, 1, 1, 0, 0, 0, 0};
        tbl[6]  = '{"g_start_long",  G, 0, 56, 1, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{"y_after_over",  Y, 0,  5, 2, 1, 0, 0, 0, 1, 1};
        tbl[8]  = '{"r_after_over",  R, 0, 30, 3, 1, 1, 0, 0, 1, 1};
        tbl[9]  = '{"g_with_clear",  G, 1, 55, 1, 1, 1, 0, 0, 0, 0};
        tbl[10] = '{"g_to_r_seq",    R, 0, 30, 3, 1, 0, 0, 1, 0, 1};
        tbl[11] = '{"r_to_g_after",  G, 0, 30, 1, 1, 1, 0, 1, 0, 1};

        step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        check_out("reset_state", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].light, tbl[i].clr, 1'b0);
            check_out(tbl[i].name, tbl[i].ph, tbl[i].lk, tbl[i].dn,
                      tbl[i].il, tbl[i].sq, tbl[i].tm, tbl[i].ct);
            hold_light(tbl[i].light, tbl[i].len - 1);
        end

        // Green overrun flags on the 56th held cycle.
        step(3'b000, 1'b0, 1'b1);
        hold_light(G, 3); hold_light(Y, 5); hold_light(R, 30);
        hold_light(G, 55);
        check_out("g55_no_err", 1, 1, 0, 0, 0, 0, 0);
        step(G, 1'b0, 1'b0);
        check_out("g56_overrun", 1, 1, 0, 0, 0, 1, 1);

        // Illegal lamp drive drops lock, then relocks without checking the first phase.
        step(3'b000, 1'b0, 1'b1);
        hold_light(G, 3); hold_light(Y, 5); hold_light(R, 30);
        step(3'b011, 1'b0, 1'b0);
        check_out("illegal_unlock", 0, 0, 0, 1, 0, 0, 1);
        step(G, 1'b0, 1'b0);
        check_out("after_illegal", 0, 0, 0, 1, 0, 0, 1);
        hold_light(G, 39);
        step(Y, 1'b0, 1'b0);
        check_out("relock", 2, 1, 0, 1, 0, 0, 1);
        hold_light(Y, 4);

        // Error counter saturation and clear colliding with an event.
        for (int i = 0; i < 150; i++) begin
            step(3'b000, 1'b0, 1'b0);
            step(3'b111, 1'b0, 1'b0);
        end
        check_out("cnt_saturate", 0, 0, 0, 1, 0, 0, 255);
        step(3'b000, 1'b1, 1'b0);
        check_out("clear_vs_event", 0, 0, 0, 1, 0, 0, 1);
        step(G, 1'b1, 1'b0);
        check_out("clear_only", 0, 0, 0, 0, 0, 0, 0);

        // Reset beats clear and an illegal value in the same cycle; history discarded.
        hold_light(G, 2); hold_light(Y, 5); hold_light(R, 10);
        step(3'b111, 1'b1, 1'b1);
        check_out("reset_wins", 0, 0, 0, 0, 0, 0, 0);
        hold_light(G, 7);
        step(Y, 1'b0, 1'b0);
        check_out("post_reset_lock", 2, 1, 0, 0, 0, 0, 0);
        hold_light(Y, 4);
        step(R, 1'b0, 1'b0);
        check_out("post_reset_done", 3, 1, 1, 0, 0, 0, 0);

        // Random phase streams against the model.
        begin
            logic [2:0] cur;
            logic [2:0] nxt;
            int len, off, kind;
            step(3'b000, 1'b0, 1'b1);
            cur = G;
            for (int s = 0; s < 150; s++) begin
                kind = $urandom_range(0, 19);
                if (kind == 0) begin
                    nxt = 3'($urandom_range(0, 7));
                    if (legal(nxt)) nxt = 3'b111;
                    step(nxt, 1'b0, 1'b0);
                end
                if (kind == 1) nxt = (succ(cur) == G) ? Y : ((succ(cur) == Y) ? R : G);
                else           nxt = succ(cur);
                off = $urandom_range(0, 5);
                len = dwell(nxt) + ((off == 0) ? -1 : (off == 1) ? 1 : (off == 2) ? 3 : 0);
                if (len < 1) len = 1;
                step(nxt, ($urandom_range(0, 9) == 0), 1'b0);
                hold_light(nxt, len - 1);
                cur = nxt;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_monitor.md
TRAFFIC_PHASE_MONITOR -- requirements
Module: traffic_phase_monitor

Interface
REQ-001 Parameter GREEN_TIME, default 55, required green dwell in clk cycles (1..254).
REQ-002 Parameter YELLOW_TIME, default 5, required yellow dwell in clk cycles (1..254).
REQ-003 Parameter RED_TIME, default 30, required red dwell in clk cycles (1..254).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 light  input  3  observed lamp drive {red, yellow, green}; legal values 3'b001 G, 3'b010 Y, 3'b100 R.
REQ-007 clearErr  input  1  synchronous clear of sticky error flags and errCount.
REQ-008 phase  output  2  registered decoded phase: 0 unknown, 1 green, 2 yellow, 3 red.
REQ-009 locked  output  1  high while in TRACK state.
REQ-010 phaseDone  output  1  one-cycle pulse: a phase ended with legal successor and exact dwell.
REQ-011 errIllegal, errSequence, errTiming  output  1 each  sticky error flags.
REQ-012 errCount  output  8  saturating error-event counter.

Function
REQ-013 Internal lightQ holds previous-cycle sample of light; "change" = light != lightQ with both legal.
REQ-014 Dwell counter cnt, 8 bits, = number of consecutive cycles lightQ has held its value; on change reloads to 1; saturates at 255.
REQ-015 States: SYNC, TRACK; reset enters SYNC.
REQ-016 SYNC: no timing or sequence checks; first change to a different legal value -> TRACK (partial first phase never checked).
REQ-017 TRACK, change: successor must be G->Y, Y->R or R->G, else set errSequence.
REQ-018 TRACK, change: ended-phase cnt must equal its *_TIME, else set errTiming.
REQ-019 TRACK, change with both checks passing: phaseDone = 1 on the following cycle only.
REQ-020 TRACK, no change and cnt reaches *_TIME+1: set errTiming immediately; no second timing error for the same phase at its eventual change.
REQ-021 Any cycle with light not in {001,010,100}: set errIllegal, -> SYNC, phase = 0; the next legal value restarts dwell at 1.
REQ-022 phase updates one cycle after light, per REQ-008 encoding; 0 whenever in SYNC.
REQ-023 Error event = any cycle setting at least one err flag; errCount += 1 per event cycle (multiple flags same cycle count once), saturates at 255.
REQ-024 clearErr clears all err flags and errCount; if an error event occurs in the same cycle, the event wins: flag(s) set, errCount = 1.
REQ-025 Sequence or timing error does not leave TRACK; tracking continues with the new phase.

Reset
REQ-026 On reset: state SYNC, lightQ = 3'b000, cnt = 0, phase = 0, locked = 0, phaseDone = 0, all err flags 0, errCount = 0.
REQ-027 Reset asserted mid-phase discards dwell history; first post-reset phase unchecked per REQ-016.
REQ-028 Reset overrides clearErr and all events in the same cycle.

Configuration
REQ-029 Macro TRAFFIC_MON_ERRCNT_EN defined: errCount implemented per REQ-023/REQ-024.
REQ-030 TRAFFIC_MON_ERRCNT_EN undefined: no counter logic; errCount tied to 8'd0; sticky flags unaffected.

Verification
REQ-031 Default params, after reset drive G 10, Y 5, R 30, G 55, Y 5 -> locked at first Y; phaseDone pulses after R->G and G->Y and Y->R; no errors.
REQ-032 Locked, green held 56 cycles -> errTiming set on cycle cnt=56, errCount = 1; following Y->R with Y 5 gives phaseDone.
REQ-033 Locked, G (55 cycles) -> R -> errSequence set, no phaseDone, errCount = 1, locked stays 1.
REQ-034 Locked, light = 3'b011 one cycle -> errIllegal set, locked = 0, phase = 0 next cycle; then G 40, Y 5 -> locked, no new errors.
REQ-035 Force 300 consecutive error cycles (alternating 3'b000/3'b111) -> errCount saturates at 255; clearErr with an illegal value same cycle -> errCount = 1, errIllegal = 1.
REQ-036 Build without TRAFFIC_MON_ERRCNT_EN, repeat REQ-033 -> errSequence = 1, errCount = 0.
